// File: rtl/rrip_victim_select_if.sv
// Victim-request, hit and fill bus between the cache controller and rrip_victim_select.
interface rrip_victim_select_if #(
   parameter int INDEX_WIDTH = 6,
   parameter int SET_SIZE    = 2,
   parameter int M           = 2
);
   logic                   halt;
   logic                   req_valid;
   logic [INDEX_WIDTH-1:0] req_index;
   logic                   req_ready;
   logic                   victim_valid;
   logic [SET_SIZE-1:0]    victim_way;
   logic                   hit_valid;
   logic [INDEX_WIDTH-1:0] hit_index;
   logic [SET_SIZE-1:0]    hit_way;
   logic                   fill_valid;
   logic [INDEX_WIDTH-1:0] fill_index;
   logic [SET_SIZE-1:0]    fill_way;
   logic [M-1:0]           fill_rrpv;

   modport master (
      output halt, req_valid, req_index, hit_valid, hit_index, hit_way,
             fill_valid, fill_index, fill_way, fill_rrpv,
      input  req_ready, victim_valid, victim_way
   );

   modport slave (
      input  halt, req_valid, req_index, hit_valid, hit_index, hit_way,
             fill_valid, fill_index, fill_way, fill_rrpv,
      output req_ready, victim_valid, victim_way
   );
endinterface

// File: rtl/rrip_victim_select.sv
// Per-set RRIP state and victim search/aging FSM for the L1 caches.
// Optional build macro RRIP_FREQ_PROMOTE_EN: hits decrement the RRPV instead of clearing it.
module rrip_victim_select #(
   parameter int ASSOCIATIVITY = 4,
   parameter int SET_SIZE      = 2,
   parameter int INDEX_WIDTH   = 6,
   parameter int DEPTH         = 64,
   parameter int M             = 2
) (
   input  logic clk,
   input  logic rst_n,
   rrip_victim_select_if.slave bus
);
   localparam logic [M-1:0] DISTANT = M'((1 << M) - 1);

   typedef enum logic [1:0] {IDLE, SCAN, AGE, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [INDEX_WIDTH-1:0] idx_reg;
   logic [SET_SIZE-1:0]    victim_way_reg;
   logic [M-1:0]           rrpv_reg  [DEPTH][ASSOCIATIVITY];
   logic [M-1:0]           rrpv_next [DEPTH][ASSOCIATIVITY];

   logic                   upd_en;
   logic                   age_en;
   logic                   accept;
   logic                   scan_hit;
   logic [SET_SIZE-1:0]    scan_way;
   logic                   req_ready_c;
   logic                   victim_valid_c;

   assign upd_en = !bus.halt;
   assign age_en = (state_reg == AGE) && upd_en;
   assign accept = (state_reg == IDLE) && bus.req_valid && upd_en;

   // Lowest-numbered way at DISTANT in the latched set, using pre-update values.
   always_comb begin
      scan_hit = 1'b0;
      scan_way = '0;
      for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
         if (rrpv_reg[idx_reg][w] == DISTANT) begin
            scan_hit = 1'b1;
            scan_way = SET_SIZE'(w);
         end
      end
   end

   // Per-entry next value: fill beats hit beats aging.
   genvar gi, gw;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_set
         for (gw = 0; gw < ASSOCIATIVITY; gw++) begin : g_way
            localparam logic [INDEX_WIDTH-1:0] SET_ID = INDEX_WIDTH'(gi);
            localparam logic [SET_SIZE-1:0]    WAY_ID = SET_SIZE'(gw);
            logic [M-1:0] cur;
            logic [M-1:0] aged;
            logic [M-1:0] promoted;
            logic         fill_sel;
            logic         hit_sel;
            logic         age_sel;

            assign cur      = rrpv_reg[gi][gw];
            assign fill_sel = upd_en && bus.fill_valid &&
                              (bus.fill_index == SET_ID) && (bus.fill_way == WAY_ID);
            assign hit_sel  = upd_en && bus.hit_valid &&
                              (bus.hit_index == SET_ID) && (bus.hit_way == WAY_ID);
            assign age_sel  = age_en && (idx_reg == SET_ID);
            // Saturate so a fill to DISTANT landing just before AGE cannot wrap.
            assign aged     = (cur == DISTANT) ? cur : cur + 1'b1;
`ifdef RRIP_FREQ_PROMOTE_EN
            assign promoted = (cur == '0) ? cur : cur - 1'b1;
`else
            assign promoted = '0;
`endif
            assign rrpv_next[gi][gw] = fill_sel ? bus.fill_rrpv :
                                       hit_sel  ? promoted      :
                                       age_sel  ? aged          : cur;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
               rrpv_reg[s][w] <= DISTANT;
            end
         end
      end else begin
         rrpv_reg <= rrpv_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         victim_way_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            idx_reg <= bus.req_index;
         end
         if ((state_reg == SCAN) && upd_en && scan_hit) begin
            victim_way_reg <= scan_way;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      req_ready_c    = 1'b0;
      victim_valid_c = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready_c = 1'b1;
            if (accept) state_next = SCAN;
         end
         SCAN: begin
            if (upd_en) state_next = scan_hit ? DONE : AGE;
         end
         AGE: begin
            if (upd_en) state_next = SCAN;
         end
         DONE: begin
            victim_valid_c = 1'b1;
            if (upd_en) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.req_ready    = req_ready_c;
   assign bus.victim_valid = victim_valid_c;
   assign bus.victim_way   = victim_way_reg;
endmodule
